// File: rtl/ctrl_pipe.sv
// Pipelined MIPS control: ID decode, ID/EX -> EX/MEM -> MEM/WB control registers,
// load-use stall and branch-flush bubbles. Optional ILLEGAL_CNT_EN adds illegal-opcode stats.
module ctrl_pipe #(
   parameter int OPW    = 3,
   parameter int RAW    = 3,
   parameter int ALUOPW = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [OPW-1:0]    id_opcode,
   input  logic [RAW-1:0]    id_rs,
   input  logic [RAW-1:0]    id_rt,
   input  logic              flush,
   output logic              stall,
   output logic              id_illegal,
   output logic              ex_regdst,
   output logic              ex_alusrc,
   output logic              ex_branch,
   output logic              ex_memwrite,
   output logic              ex_memread,
   output logic              ex_memtoreg,
   output logic              ex_regwrite,
   output logic [ALUOPW-1:0] ex_aluop,
   output logic              mem_branch,
   output logic              mem_memwrite,
   output logic              mem_memread,
   output logic              mem_memtoreg,
   output logic              mem_regwrite,
   output logic              wb_memtoreg,
   output logic              wb_regwrite
`ifdef ILLEGAL_CNT_EN
   ,
   output logic [7:0]        illegal_cnt,
   output logic              illegal_seen
`endif
);

   localparam logic [31:0] OP_RTYPE = 32'd0;
   localparam logic [31:0] OP_BEQ   = 32'd2;
   localparam logic [31:0] OP_ADDI  = 32'd3;
   localparam logic [31:0] OP_LW    = 32'd5;
   localparam logic [31:0] OP_SW    = 32'd6;

   typedef struct packed {
      logic              regWrite;
      logic              regDst;
      logic              aluSrc;
      logic [ALUOPW-1:0] aluOp;
      logic              branch;
      logic              memWrite;
      logic              memRead;
      logic              memToReg;
   } exCtrlT;

   typedef struct packed {
      logic branch;
      logic memWrite;
      logic memRead;
      logic memToReg;
      logic regWrite;
   } memCtrlT;

   typedef struct packed {
      logic memToReg;
      logic regWrite;
   } wbCtrlT;

   logic [31:0] opExt;
   exCtrlT      decCtrl;
   logic        decLegal;

   exCtrlT      idExReg, idExNext;
   logic [RAW-1:0] exRtReg, exRtNext;
   memCtrlT     exMemReg, exMemNext;
   wbCtrlT      memWbReg;

   // Opcodes wider than 3 bits are compared zero-extended, so any high bit set is illegal.
   assign opExt = 32'(id_opcode);

   always_comb begin
      decCtrl  = '0;
      decLegal = 1'b0;
      case (opExt)
         OP_RTYPE: begin
            decLegal         = 1'b1;
            decCtrl.regWrite = 1'b1;
            decCtrl.regDst   = 1'b1;
            decCtrl.aluOp    = ALUOPW'(2);
         end
         OP_BEQ: begin
            decLegal       = 1'b1;
            decCtrl.aluOp  = ALUOPW'(1);
            decCtrl.branch = 1'b1;
         end
         OP_ADDI: begin
            decLegal         = 1'b1;
            decCtrl.regWrite = 1'b1;
            decCtrl.aluSrc   = 1'b1;
         end
         OP_LW: begin
            decLegal         = 1'b1;
            decCtrl.regWrite = 1'b1;
            decCtrl.aluSrc   = 1'b1;
            decCtrl.memRead  = 1'b1;
            decCtrl.memToReg = 1'b1;
         end
         OP_SW: begin
            decLegal         = 1'b1;
            decCtrl.aluSrc   = 1'b1;
            decCtrl.memWrite = 1'b1;
         end
         default: begin
            decLegal = 1'b0;
            decCtrl  = '0;
         end
      endcase
      if (!id_valid) begin
         decCtrl = '0;
      end
   end

   assign id_illegal = id_valid & ~decLegal;

   // Load in EX whose destination feeds the ID instruction: its data is not ready yet.
   assign stall = id_valid & idExReg.memRead &
                  ((exRtReg == id_rs) | (exRtReg == id_rt));

   always_comb begin
      idExNext = decCtrl;
      exRtNext = id_rt;
      if (flush || stall) begin
         idExNext = '0;
         exRtNext = '0;
      end
   end

   always_comb begin
      exMemNext.branch   = idExReg.branch;
      exMemNext.memWrite = idExReg.memWrite;
      exMemNext.memRead  = idExReg.memRead;
      exMemNext.memToReg = idExReg.memToReg;
      exMemNext.regWrite = idExReg.regWrite;
      if (flush) begin
         exMemNext = '0;
      end
   end

   // MEM/WB is never flushed so the branch resolving in MEM still retires.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         idExReg  <= '0;
         exRtReg  <= '0;
         exMemReg <= '0;
         memWbReg <= '0;
      end else begin
         idExReg           <= idExNext;
         exRtReg           <= exRtNext;
         exMemReg          <= exMemNext;
         memWbReg.memToReg <= exMemReg.memToReg;
         memWbReg.regWrite <= exMemReg.regWrite;
      end
   end

   assign ex_regdst    = idExReg.regDst;
   assign ex_alusrc    = idExReg.aluSrc;
   assign ex_branch    = idExReg.branch;
   assign ex_memwrite  = idExReg.memWrite;
   assign ex_memread   = idExReg.memRead;
   assign ex_memtoreg  = idExReg.memToReg;
   assign ex_regwrite  = idExReg.regWrite;
   assign ex_aluop     = idExReg.aluOp;

   assign mem_branch   = exMemReg.branch;
   assign mem_memwrite = exMemReg.memWrite;
   assign mem_memread  = exMemReg.memRead;
   assign mem_memtoreg = exMemReg.memToReg;
   assign mem_regwrite = exMemReg.regWrite;

   assign wb_memtoreg  = memWbReg.memToReg;
   assign wb_regwrite  = memWbReg.regWrite;

`ifdef ILLEGAL_CNT_EN
   logic [7:0] illegalCntReg;
   logic       illegalSeenReg;

   // A stalled cycle re-presents the same instruction next cycle, so it is counted once.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         illegalCntReg  <= '0;
         illegalSeenReg <= 1'b0;
      end else begin
         if (id_illegal && !stall && (illegalCntReg != 8'hFF)) begin
            illegalCntReg <= illegalCntReg + 8'd1;
         end
         if (id_illegal) begin
            illegalSeenReg <= 1'b1;
         end
      end
   end

   assign illegal_cnt  = illegalCntReg;
   assign illegal_seen = illegalSeenReg;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Randomised + directed bench for ctrl_pipe against an instruction-level pipeline model.
module tb_ctrl_pipe;

   logic       clock;
   logic       reset;
   logic       id_valid;
   logic [2:0] id_opcode;
   logic [2:0] id_rs;
   logic [2:0] id_rt;
   logic       flush;
   logic       stall;
   logic       id_illegal;
   logic       ex_regdst, ex_alusrc, ex_branch, ex_memwrite, ex_memread, ex_memtoreg, ex_regwrite;
   logic [1:0] ex_aluop;
   logic       mem_branch, mem_memwrite, mem_memread, mem_memtoreg, mem_regwrite;
   logic       wb_memtoreg, wb_regwrite;
`ifdef ILLEGAL_CNT_EN
   logic [7:0] illegal_cnt;
   logic       illegal_seen;
`endif

   int errors = 0;
   int checks = 0;

   ctrl_pipe #(.OPW(3), .RAW(3), .ALUOPW(2)) dut (
      .clock(clock), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs(id_rs), .id_rt(id_rt), .flush(flush), .stall(stall), .id_illegal(id_illegal),
      .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_branch(ex_branch),
      .ex_memwrite(ex_memwrite), .ex_memread(ex_memread), .ex_memtoreg(ex_memtoreg),
      .ex_regwrite(ex_regwrite), .ex_aluop(ex_aluop),
      .mem_branch(mem_branch), .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
      .mem_memtoreg(mem_memtoreg), .mem_regwrite(mem_regwrite),
      .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite)
`ifdef ILLEGAL_CNT_EN
      , .illegal_cnt(illegal_cnt), .illegal_seen(illegal_seen)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Model: each stage holds an instruction (or a bubble); control is derived from the opcode.
   typedef struct { bit live; int op; int rt; } instT;
   typedef struct { bit rw; bit rd; bit as; int aop; bit br; bit mw; bit mr; bit mt; } ctlT;

   instT exS, memS, wbS;
   int   mCnt;
   bit   mSeen;

   function automatic instT bubble();
      instT b;
      b.live = 0; b.op = 0; b.rt = 0;
      return b;
   endfunction

   function automatic ctlT ctlOf(instT s);
      ctlT c = '{0, 0, 0, 0, 0, 0, 0, 0};
      if (!s.live) return c;
      case (s.op)
         0: c = '{1, 1, 0, 2, 0, 0, 0, 0};
         2: c = '{0, 0, 0, 1, 1, 0, 0, 0};
         3: c = '{1, 0, 1, 0, 0, 0, 0, 0};
         5: c = '{1, 0, 1, 0, 0, 0, 1, 1};
         6: c = '{0, 0, 1, 0, 0, 1, 0, 0};
         default: c = '{0, 0, 0, 0, 0, 0, 0, 0};
      endcase
      return c;
   endfunction

   function automatic bit expIllegal();
      int op = int'(id_opcode);
      return id_valid && !(op == 0 || op == 2 || op == 3 || op == 5 || op == 6);
   endfunction

   function automatic bit expStall();
      return id_valid && exS.live && exS.op == 5 &&
             (exS.rt == int'(id_rs) || exS.rt == int'(id_rt));
   endfunction

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic compareAll();
      ctlT e = ctlOf(exS);
      ctlT m = ctlOf(memS);
      ctlT w = ctlOf(wbS);
      checkVal("ex", 32'({ex_regwrite, ex_regdst, ex_alusrc, ex_aluop, ex_branch,
                          ex_memwrite, ex_memread, ex_memtoreg}),
               32'({e.rw, e.rd, e.as, 2'(e.aop), e.br, e.mw, e.mr, e.mt}));
      checkVal("mem", 32'({mem_branch, mem_memwrite, mem_memread, mem_memtoreg, mem_regwrite}),
               32'({m.br, m.mw, m.mr, m.mt, m.rw}));
      checkVal("wb", 32'({wb_memtoreg, wb_regwrite}), 32'({w.mt, w.rw}));
      checkVal("stall", 32'(stall), 32'(expStall()));
      checkVal("illegal", 32'(id_illegal), 32'(expIllegal()));
`ifdef ILLEGAL_CNT_EN
      checkVal("illegal_cnt", 32'(illegal_cnt), 32'(mCnt));
      checkVal("illegal_seen", 32'(illegal_seen), 32'(mSeen));
`endif
   endtask

   task automatic modelReset();
      exS = bubble(); memS = bubble(); wbS = bubble();
      mCnt = 0; mSeen = 0;
   endtask

   task automatic modelStep();
      bit   s  = expStall();
      bit   il = expIllegal();
      instT n;
      n.live = id_valid; n.op = int'(id_opcode); n.rt = int'(id_rt);
      wbS  = memS;
      memS = flush ? bubble() : exS;
      exS  = (flush || s) ? bubble() : n;
      if (il && !s && mCnt < 255) mCnt++;
      if (il) mSeen = 1;
   endtask

   // One clocked transaction: drive, check, clock, advance model.
   task automatic cycle(input bit v, input int op, input int rs, input int rt, input bit fl,
                        output bit st);
      id_valid = v; id_opcode = 3'(op); id_rs = 3'(rs); id_rt = 3'(rt); flush = fl;
      #1;
      st = expStall();
      compareAll();
      $display("cyc t=%0t v=%0b op=%0d rs=%0d rt=%0d flush=%0b stall=%0b",
               $time, v, op, rs, rt, fl, st);
      @(posedge clock);
      if (reset) modelStep();
      #1;
   endtask

   bit st;
   int cv, cop, crs, crt;

   initial begin
      modelReset();
      reset = 1'b0; id_valid = 1'b1; id_opcode = 3'd0; id_rs = 3'd1; id_rt = 3'd2; flush = 1'b0;

      // Reset held with a valid R-type presented: everything stays zero.
      @(posedge clock); #1;
      compareAll();
      @(posedge clock); #1;
      compareAll();
      #2 reset = 1'b1;
      cycle(1, 0, 1, 2, 0, st);
      checkVal("rst_release_regwrite", 32'(ex_regwrite), 32'd1);
      checkVal("rst_release_aluop", 32'(ex_aluop), 32'd2);

      // Latency of a single LW through the stages.
      cycle(1, 5, 1, 2, 0, st);
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, st);

      // Load-use hazard on rs: one stall, then the held R-type enters EX.
      cycle(1, 5, 1, 3, 0, st);
      cycle(1, 0, 3, 6, 0, st);
      checkVal("loaduse_stall", 32'(st), 32'd1);
      cycle(1, 0, 3, 6, 0, st);
      checkVal("loaduse_release", 32'(st), 32'd0);
      checkVal("loaduse_rtype_ex", 32'(ex_regdst), 32'd1);
      // No dependence: no stall.
      cycle(1, 5, 1, 3, 0, st);
      cycle(1, 0, 4, 5, 0, st);
      checkVal("nodep_stall", 32'(st), 32'd0);
      // Back-to-back loads with a repeated dependence stall only once.
      cycle(1, 5, 1, 2, 0, st);
      cycle(1, 5, 2, 7, 0, st);
      cycle(1, 5, 2, 7, 0, st);
      cycle(1, 0, 0, 0, 0, st);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, st);

      // Flush when the BEQ sits in MEM.
      cycle(1, 2, 1, 2, 0, st);
      cycle(1, 3, 1, 4, 0, st);
      cycle(1, 3, 2, 5, 1, st);
      checkVal("flush_ex_regwrite", 32'(ex_regwrite), 32'd0);
      checkVal("flush_mem_regwrite", 32'(mem_regwrite), 32'd0);
      checkVal("flush_wb_regwrite", 32'(wb_regwrite), 32'd0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, st);

      // Flush coinciding with a stall still yields a bubble.
      cycle(1, 5, 0, 1, 0, st);
      cycle(1, 0, 1, 1, 1, st);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, st);

      // Randomised traffic honouring the IF/ID hold on stall.
      st = 0;
      for (int i = 0; i < 400; i++) begin
         if (!st) begin
            cv  = ($urandom_range(0, 9) < 8) ? 1 : 0;
            cop = $urandom_range(0, 7);
            crs = $urandom_range(0, 3);
            crt = $urandom_range(0, 3);
         end
         cycle(cv[0], cop, crs, crt, ($urandom_range(0, 9) == 0), st);
      end

      // Async reset between edges during an LW/SW stream.
      cycle(1, 5, 1, 2, 0, st);
      cycle(1, 6, 3, 4, 0, st);
      id_valid = 1'b1; id_opcode = 3'd5; id_rs = 3'd5; id_rt = 3'd6; flush = 1'b0;
      #2 reset = 1'b0;
      modelReset();
      #1;
      compareAll();
      checkVal("async_ex_memread", 32'(ex_memread), 32'd0);
      checkVal("async_mem_memwrite", 32'(mem_memwrite), 32'd0);
      @(posedge clock); #1;
      compareAll();
      #2 reset = 1'b1;
      cycle(1, 5, 5, 6, 0, st);
      cycle(1, 0, 6, 1, 0, st);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, st);

      // Long illegal run: zeros propagate and the counter saturates.
      for (int i = 0; i < 300; i++) cycle(1, 7, i % 8, (i + 1) % 8, 0, st);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, st);
`ifdef ILLEGAL_CNT_EN
      checkVal("illegal_cnt_sat", 32'(illegal_cnt), 32'd255);
      checkVal("illegal_seen_sticky", 32'(illegal_seen), 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
Parametrised successor to the single-stage opcode decoder. It decodes the ID-stage opcode and carries the control bits through the ID/EX, EX/MEM and MEM/WB pipeline registers. It detects load-use hazards and inserts bubbles on stall or branch flush. It sits between the IF/ID register and the datapath stage muxes of the pipelined MIPS core.

Parameters:
OPW, 3, opcode width; opcodes are zero-extended for comparison.
RAW, 3, register-address width for hazard comparison.
ALUOPW, 2, ALUOp field width (min 2).

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
id_valid  input  1  ID stage holds a real instruction
id_opcode  input  OPW  opcode from IF/ID
id_rs  input  RAW  first source register from IF/ID
id_rt  input  RAW  second source/dest register from IF/ID
flush  input  1  branch taken; kill younger instructions
stall  output  1  load-use hazard; upstream must hold PC and IF/ID
id_illegal  output  1  combinational: id_valid and undefined opcode
ex_regdst, ex_alusrc, ex_branch, ex_memwrite, ex_memread, ex_memtoreg, ex_regwrite  output  1 each  ID/EX control
ex_aluop  output  ALUOPW  ID/EX ALU operation
mem_branch, mem_memwrite, mem_memread, mem_memtoreg, mem_regwrite  output  1 each  EX/MEM control
wb_memtoreg, wb_regwrite  output  1 each  MEM/WB control

Behaviour:
- Decode table (RegWrite, RegDst, ALUSrc, ALUOp, Branch, MemWrite, MemRead, MemtoReg):
  - op 0 R-type: 1,1,0,2,0,0,0,0
  - op 2 BEQ: 0,0,0,1,1,0,0,0
  - op 3 ADDI: 1,0,1,0,0,0,0,0
  - op 5 LW: 1,0,1,0,0,0,1,1
  - op 6 SW: 0,0,1,0,0,1,0,0
  - Any other value (incl. 1, 4, 7, and >=8 when OPW>3): all 0, and id_illegal=1 when id_valid.
- id_valid=0 decodes as all zeros.
- Pipeline registers:
  - ID/EX also holds ex_rt (RAW bits) internally.
  - Latency from id_opcode to ex_* is 1 cycle, to mem_* is 2 cycles, to wb_* is 3 cycles.
  - EX/MEM copies the relevant ID/EX bits every cycle; MEM/WB copies the relevant EX/MEM bits every cycle.
  - There is no hold in the EX, MEM or WB stages.
- Hazard detection:
  - stall = id_valid & ex_memread & ((ex_rt==id_rs) | (ex_rt==id_rt)).
  - stall is purely combinational from registered state and inputs.
  - On stall, ID/EX loads a bubble (all control 0, ex_rt=0). The IF/ID hold is external.
- Flush:
  - flush=1 loads a bubble into both ID/EX and EX/MEM at the next edge.
  - MEM/WB still captures the old EX/MEM contents, so the branch in MEM completes.
- Priority at ID/EX: flush > stall > decode. When stall and flush coincide, the result is a bubble.
- Reset (reset=0, asynchronous):
  - All pipeline registers clear to 0, so every ex_/mem_/wb_ output is 0 and stall is 0.
  - Deassertion is sampled at the next rising edge.
  - Reset asserted mid-operation discards all in-flight control with no partial writes.
- Back-to-back loads: a second LW stalled behind a first LW is re-decoded after the bubble. No double stall occurs unless the register dependence repeats.

Optional Feature:
ILLEGAL_CNT_EN
- Defined:
  - Adds output illegal_cnt [7:0], which counts cycles where id_illegal=1 and stall=0.
  - The count saturates at 255 and clears on reset.
  - Adds output illegal_seen, a sticky 1 after the first illegal opcode.
- Undefined: neither port exists and the logic is absent. All other behaviour is identical.

Test Plan:
- Reset check: hold reset=0 with id_opcode=0 and id_valid=1, then release. All outputs are 0 during reset. ex_regwrite=1, ex_regdst=1, ex_aluop=2 one cycle after release.
- Latency check: issue LW (op 5) for one cycle, then id_valid=0. ex_memread=1 at T+1, mem_memread=1 at T+2, wb_memtoreg=1 and wb_regwrite=1 at T+3, all 0 afterwards.
- Load-use stall: LW with rt=3, then R-type with rs=3. stall=1 for exactly one cycle and ID/EX holds a bubble. The R-type appears in EX one cycle later. With rs=4 and rt=5 instead, no stall occurs.
- Flush: BEQ then ADDI, with flush=1 in the cycle the BEQ reaches MEM. The next cycle ex_* and mem_* are all 0, and wb_regwrite=0 for the BEQ.
- Illegal opcode: op 7 with id_valid=1 gives id_illegal=1 and zeros propagate through all stages. With ILLEGAL_CNT_EN and 300 illegal cycles, illegal_cnt=255.
- Async reset mid-stream: assert reset between clock edges during an LW/SW sequence. Outputs go to 0 immediately, without waiting for a clock edge.
